// File: rtl/imm_ext_ctrl_if.sv
// Handshake bundle between the decoder, the immediate-extension stage and the
// downstream consumer.
//   upstream   : IN_VALID, IN_READY, INSTR[31:0], IMM_SEL[1:0], FLUSH
//   downstream : OUT_VALID, OUT_READY, EXT[31:0], EXT_CNT[CNT_W-1:0]
// master = the side that drives the stage (decoder plus consumer),
// slave  = the stage itself.
interface imm_ext_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             IN_VALID;
  logic             IN_READY;
  logic [31:0]      INSTR;
  logic [1:0]       IMM_SEL;
  logic             FLUSH;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [31:0]      EXT;
  logic [CNT_W-1:0] EXT_CNT;

  modport master (
    output IN_VALID, INSTR, IMM_SEL, FLUSH, OUT_READY,
    input  IN_READY, OUT_VALID, EXT, EXT_CNT
  );

  modport slave (
    input  IN_VALID, INSTR, IMM_SEL, FLUSH, OUT_READY,
    output IN_READY, OUT_VALID, EXT, EXT_CNT
  );
endinterface

// File: rtl/imm_ext_ctrl.sv
// Registered immediate-extension stage.
// The immediate field of INSTR is extended combinationally according to
// IMM_SEL and stored already-extended in a 2-entry skid buffer (main + skid).
// The main entry drives EXT/OUT_VALID. IN_READY is the registered inverse of
// the skid-valid flag, so it never depends combinationally on OUT_READY.
// A wrapping counter tracks completed output transfers.
// Ports:
//   CLK  - clock, all state on the rising edge
//   RST  - synchronous active-high reset (priority over FLUSH)
//   bus  - imm_ext_ctrl_if.slave: IN_VALID/IN_READY/INSTR/IMM_SEL/FLUSH in,
//          OUT_VALID/OUT_READY/EXT/EXT_CNT out
module imm_ext_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  imm_ext_ctrl_if.slave bus
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned HALF_W = 16;

  // Buffer state
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              in_ready_q;
  logic [CNT_W-1:0]  cnt;

  // Next-state values
  logic              m_valid_d;
  logic [DATA_W-1:0] m_data_d;
  logic              s_valid_d;
  logic [DATA_W-1:0] s_data_d;
  logic              in_ready_d;
  logic [CNT_W-1:0]  cnt_d;

  logic [DATA_W-1:0] ext_c;
  logic              accept_c;
  logic              consume_c;

  // Immediate selection and extension
  always_comb begin
    ext_c = '0;
    unique case (bus.IMM_SEL)
      2'b00:   ext_c = {{HALF_W{bus.INSTR[15]}}, bus.INSTR[15:0]};
      2'b01:   ext_c = {{HALF_W{1'b0}}, bus.INSTR[15:0]};
      2'b10:   ext_c = {{11{bus.INSTR[20]}}, bus.INSTR[20:0]};
      default: ext_c = {bus.INSTR[15:0], {HALF_W{1'b0}}};
    endcase
  end

  assign accept_c  = bus.IN_VALID & in_ready_q;
  assign consume_c = m_valid & bus.OUT_READY;

  // Buffer next-state; the counter still advances on a consume during FLUSH
  always_comb begin
    m_valid_d = m_valid;
    m_data_d  = m_data;
    s_valid_d = s_valid;
    s_data_d  = s_data;
    cnt_d     = cnt + CNT_W'(consume_c);

    if (bus.FLUSH) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!m_valid || consume_c) begin
      // Main slot frees up: refill from skid first to keep ordering
      if (s_valid) begin
        m_valid_d = 1'b1;
        m_data_d  = s_data;
        s_valid_d = accept_c;
        if (accept_c) begin
          s_data_d = ext_c;
        end
      end else begin
        m_valid_d = accept_c;
        if (accept_c) begin
          m_data_d = ext_c;
        end
      end
    end else if (accept_c) begin
      // Main stalled: park the new word in the skid slot
      s_valid_d = 1'b1;
      s_data_d  = ext_c;
    end

    in_ready_d = ~s_valid_d;
  end

  // State registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      m_valid    <= 1'b0;
      m_data     <= '0;
      s_valid    <= 1'b0;
      s_data     <= '0;
      in_ready_q <= 1'b1;
      cnt        <= '0;
    end else begin
      m_valid    <= m_valid_d;
      m_data     <= m_data_d;
      s_valid    <= s_valid_d;
      s_data     <= s_data_d;
      in_ready_q <= in_ready_d;
      cnt        <= cnt_d;
    end
  end

  assign bus.IN_READY  = in_ready_q;
  assign bus.OUT_VALID = m_valid;
  assign bus.EXT       = m_data;
  assign bus.EXT_CNT   = cnt;

endmodule

// File: tb/tb_imm_ext_ctrl.sv
// Bench for imm_ext_ctrl: a 16-bit-counter instance and a 4-bit-counter
// instance see identical stimulus. Reference model is a queue of extended
// words plus an unbounded transfer count.
module tb_imm_ext_ctrl;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  imm_ext_ctrl_if #(.CNT_W(16)) bus ();
  imm_ext_ctrl_if #(.CNT_W(4))  bus4 ();

  assign bus4.IN_VALID  = bus.IN_VALID;
  assign bus4.INSTR     = bus.INSTR;
  assign bus4.IMM_SEL   = bus.IMM_SEL;
  assign bus4.FLUSH     = bus.FLUSH;
  assign bus4.OUT_READY = bus.OUT_READY;

  imm_ext_ctrl #(.CNT_W(16)) dut  (.CLK(CLK), .RST(RST), .bus(bus));
  imm_ext_ctrl #(.CNT_W(4))  dut4 (.CLK(CLK), .RST(RST), .bus(bus4));

  int total = 0;
  int bad   = 0;

  logic [31:0] q[$];     // model buffer contents, oldest first
  logic [31:0] got[$];   // words observed leaving the 16-bit instance
  int unsigned mcnt;     // model transfer count, reduced modulo on compare

  function automatic logic [31:0] ref_ext(input logic [31:0] i, input logic [1:0] s);
    longint v;
    case (s)
      2'd0: begin v = longint'(i[15:0]); if (i[15]) v = v - 65536; end
      2'd1: v = longint'(i[15:0]);
      2'd2: begin v = longint'(i[20:0]); if (i[20]) v = v - 2097152; end
      default: v = longint'(i[15:0]) * 65536;
    endcase
    return 32'(v);
  endfunction

  task automatic set_in(input logic v, input logic [31:0] i, input logic [1:0] s,
                        input logic fl, input logic ordy);
    bus.IN_VALID  = v;
    bus.INSTR     = i;
    bus.IMM_SEL   = s;
    bus.FLUSH     = fl;
    bus.OUT_READY = ordy;
  endtask

  // One clock: record any transfer, advance the model, settle past the edge
  task automatic step();
    logic acc, con;
    logic [31:0] nv;
    acc = bus.IN_VALID && (q.size() < 2);
    con = (q.size() > 0) && bus.OUT_READY;
    nv  = ref_ext(bus.INSTR, bus.IMM_SEL);
    if (bus.OUT_VALID && bus.OUT_READY && !RST) got.push_back(bus.EXT);
    @(posedge CLK);
    if (RST) begin
      q.delete();
      mcnt = 0;
    end else begin
      if (con) mcnt++;
      if (bus.FLUSH) q.delete();
      else begin
        if (con) void'(q.pop_front());
        if (acc) q.push_back(nv);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    set_in(1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
    step();
    RST = 1'b0;
    got.delete();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({bus.OUT_VALID, bus.IN_READY, bus.EXT, bus.EXT_CNT, bus4.EXT_CNT} !== {1'b0, 1'b1, 32'h0, 16'h0, 4'h0}) begin
      bad++;
      $display("FAIL reset_state got ov=%b ir=%b ext=%h cnt=%h cnt4=%h exp 0 1 00000000 0000 0",
               bus.OUT_VALID, bus.IN_READY, bus.EXT, bus.EXT_CNT, bus4.EXT_CNT);
    end
  endtask

  task automatic test_formats();
    logic [31:0] fi[4];
    logic [1:0]  fs[4];
    logic [31:0] fe[4];
    fi = '{32'h0000_8001, 32'h0000_8001, 32'h0000_8001, 32'h0010_0000};
    fs = '{2'd0, 2'd1, 2'd3, 2'd2};
    fe = '{32'hFFFF_8001, 32'h0000_8001, 32'h8001_0000, 32'hFFF0_0000};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, fi[k], fs[k], 1'b0, 1'b1);
      step();
      total++;
      if (bus.OUT_VALID !== 1'b1 || bus.EXT !== fe[k]) begin
        bad++;
        $display("FAIL fmt_ext k=%0d got ov=%b ext=%h exp ov=1 ext=%h", k, bus.OUT_VALID, bus.EXT, fe[k]);
      end
    end
    set_in(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
    step();
    total++;
    if (bus.EXT_CNT !== 16'd4 || bus.OUT_VALID !== 1'b0) begin
      bad++;
      $display("FAIL fmt_cnt got cnt=%0d ov=%b exp cnt=4 ov=0", bus.EXT_CNT, bus.OUT_VALID);
    end
    total++;
    if (got.size() != 4) begin
      bad++;
      $display("FAIL fmt_seq got %0d words exp 4", got.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (got[k] !== fe[k]) begin
          bad++;
          $display("FAIL fmt_seq k=%0d got=%h exp=%h", k, got[k], fe[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w[3];
    logic [31:0] e[3];
    int budget;
    for (int k = 0; k < 3; k++) begin
      w[k] = $urandom;
      e[k] = ref_ext(w[k], 2'd0);
    end
    do_reset();
    set_in(1'b1, w[0], 2'd0, 1'b0, 1'b0);
    step();
    set_in(1'b1, w[1], 2'd0, 1'b0, 1'b0);
    step();
    total++;
    if ({bus.OUT_VALID, bus.IN_READY} !== 2'b10 || bus.EXT !== e[0]) begin
      bad++;
      $display("FAIL bp_full got ov=%b ir=%b ext=%h exp ov=1 ir=0 ext=%h", bus.OUT_VALID, bus.IN_READY, bus.EXT, e[0]);
    end
    // C is offered while the buffer is full and must be held upstream
    set_in(1'b1, w[2], 2'd0, 1'b0, 1'b0);
    step();
    total++;
    if ({bus.OUT_VALID, bus.IN_READY} !== 2'b10 || bus.EXT !== e[0]) begin
      bad++;
      $display("FAIL bp_hold got ov=%b ir=%b ext=%h exp ov=1 ir=0 ext=%h", bus.OUT_VALID, bus.IN_READY, bus.EXT, e[0]);
    end
    budget = 0;
    bus.OUT_READY = 1'b1;
    while (got.size() < 3 && budget < 12) begin
      if (bus.IN_VALID && bus.IN_READY) begin
        step();
        bus.IN_VALID = 1'b0;
      end else step();
      budget++;
    end
    total++;
    if (got.size() != 3) begin
      bad++;
      $display("FAIL bp_drain got %0d words in %0d cycles exp 3", got.size(), budget);
    end else begin
      for (int k = 0; k < 3; k++) begin
        total++;
        if (got[k] !== e[k]) begin
          bad++;
          $display("FAIL bp_order k=%0d got=%h exp=%h", k, got[k], e[k]);
        end
      end
    end
  endtask

  task automatic test_drain_accept();
    logic [31:0] a, b, c;
    a = $urandom; b = $urandom; c = $urandom;
    do_reset();
    set_in(1'b1, a, 2'd1, 1'b0, 1'b0);
    step();
    set_in(1'b1, b, 2'd1, 1'b0, 1'b0);
    step();
    set_in(1'b1, c, 2'd1, 1'b0, 1'b1);
    step();
    total++;
    if ({bus.OUT_VALID, bus.IN_READY} !== 2'b11 || bus.EXT !== ref_ext(b, 2'd1)) begin
      bad++;
      $display("FAIL da_first got ov=%b ir=%b ext=%h exp ov=1 ir=1 ext=%h",
               bus.OUT_VALID, bus.IN_READY, bus.EXT, ref_ext(b, 2'd1));
    end
    step();
    total++;
    if (bus.OUT_VALID !== 1'b1 || bus.EXT !== ref_ext(c, 2'd1)) begin
      bad++;
      $display("FAIL da_second got ov=%b ext=%h exp ov=1 ext=%h", bus.OUT_VALID, bus.EXT, ref_ext(c, 2'd1));
    end
    set_in(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
    step();
    total++;
    if (got.size() != 3 || got[0] !== ref_ext(a, 2'd1) || got[1] !== ref_ext(b, 2'd1) || got[2] !== ref_ext(c, 2'd1)) begin
      bad++;
      $display("FAIL da_order got n=%0d exp 3 words A,B,C in order", got.size());
    end
  endtask

  task automatic test_flush();
    do_reset();
    set_in(1'b1, 32'h1234_5678, 2'd0, 1'b0, 1'b0);
    step();
    set_in(1'b1, 32'h9ABC_DEF0, 2'd0, 1'b0, 1'b0);
    step();
    set_in(1'b1, 32'h0F0F_0F0F, 2'd0, 1'b1, 1'b0);
    step();
    total++;
    if ({bus.OUT_VALID, bus.IN_READY, bus.EXT_CNT} !== {1'b0, 1'b1, 16'd0}) begin
      bad++;
      $display("FAIL flush_state got ov=%b ir=%b cnt=%0d exp ov=0 ir=1 cnt=0", bus.OUT_VALID, bus.IN_READY, bus.EXT_CNT);
    end
    set_in(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (bus.OUT_VALID !== 1'b0 || got.size() != 0) begin
        bad++;
        $display("FAIL flush_ghost k=%0d got ov=%b n=%0d exp ov=0 n=0", k, bus.OUT_VALID, got.size());
      end
    end
    // A consume coinciding with FLUSH still counts
    set_in(1'b1, 32'h0000_0042, 2'd1, 1'b0, 1'b0);
    step();
    set_in(1'b0, 32'h0, 2'd0, 1'b1, 1'b1);
    step();
    total++;
    if ({bus.OUT_VALID, bus.EXT_CNT, bus4.EXT_CNT} !== {1'b0, 16'd1, 4'd1}) begin
      bad++;
      $display("FAIL flush_consume got ov=%b cnt=%0d cnt4=%0d exp ov=0 cnt=1 cnt4=1", bus.OUT_VALID, bus.EXT_CNT, bus4.EXT_CNT);
    end
    bus.FLUSH = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_in(1'b1, $urandom, 2'($urandom), 1'b0, 1'b1);
      step();
    end
    set_in(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
    step();
    total++;
    if (bus.EXT_CNT !== 16'd5) begin
      bad++;
      $display("FAIL rm_count got=%0d exp=5", bus.EXT_CNT);
    end
    set_in(1'b1, 32'hFFFF_FFFF, 2'd0, 1'b0, 1'b0);
    step();
    step();
    total++;
    if ({bus.OUT_VALID, bus.IN_READY} !== 2'b10) begin
      bad++;
      $display("FAIL rm_full got ov=%b ir=%b exp ov=1 ir=0", bus.OUT_VALID, bus.IN_READY);
    end
    RST = 1'b1;
    step();
    RST = 1'b0;
    total++;
    if ({bus.OUT_VALID, bus.IN_READY, bus.EXT, bus.EXT_CNT, bus4.EXT_CNT} !== {1'b0, 1'b1, 32'h0, 16'h0, 4'h0}) begin
      bad++;
      $display("FAIL rm_state got ov=%b ir=%b ext=%h cnt=%h cnt4=%h exp 0 1 00000000 0000 0",
               bus.OUT_VALID, bus.IN_READY, bus.EXT, bus.EXT_CNT, bus4.EXT_CNT);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 17; k++) begin
      set_in(1'b1, $urandom, 2'($urandom), 1'b0, 1'b1);
      step();
    end
    set_in(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
    step();
    total++;
    if (bus4.EXT_CNT !== 4'd1 || bus.EXT_CNT !== 16'd17) begin
      bad++;
      $display("FAIL wrap got cnt4=%0d cnt=%0d exp cnt4=1 cnt=17", bus4.EXT_CNT, bus.EXT_CNT);
    end
  endtask

  task automatic test_random();
    logic        pv, taken, fl, r;
    logic [31:0] pi;
    logic [1:0]  ps;
    logic [21:0] exp_ctl;
    do_reset();
    pv = 1'b0; pi = '0; ps = '0;
    for (int c = 0; c < 400; c++) begin
      if (!pv && $urandom_range(0, 3) != 0) begin
        pv = 1'b1;
        pi = $urandom;
        ps = 2'($urandom);
      end
      fl = ($urandom_range(0, 19) == 0);
      r  = ($urandom_range(0, 99) == 0);
      set_in(pv, pi, ps, fl, 1'($urandom_range(0, 3) != 0));
      RST = r;
      taken = pv && bus.IN_READY;
      step();
      RST = 1'b0;
      if (taken) pv = 1'b0;
      total++;
      exp_ctl = {q.size() > 0, q.size() < 2, 16'(mcnt), 4'(mcnt)};
      if ({bus.OUT_VALID, bus.IN_READY, bus.EXT_CNT, bus4.EXT_CNT} !== exp_ctl) begin
        bad++;
        $display("FAIL rand_ctl cyc=%0d got=%h exp=%h", c,
                 {bus.OUT_VALID, bus.IN_READY, bus.EXT_CNT, bus4.EXT_CNT}, exp_ctl);
      end
      if (q.size() > 0) begin
        total++;
        if (bus.EXT !== q[0] || bus4.EXT !== q[0]) begin
          bad++;
          $display("FAIL rand_ext cyc=%0d got=%h/%h exp=%h", c, bus.EXT, bus4.EXT, q[0]);
        end
      end
    end
    set_in(1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
  endtask

  initial begin
    RST  = 1'b1;
    mcnt = 0;
    set_in(1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
    test_reset();
    test_formats();
    test_backpressure();
    test_drain_accept();
    test_flush();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/imm_ext_ctrl.md
Name: imm_ext_ctrl

Overview:
- Registered immediate-extension stage for the single-cycle CPU datapath.
- Accepts a 32-bit instruction word and a format select from the decoder over a valid/ready handshake.
- Selects and sign-/zero-extends the immediate field to 32 bits, then presents the result downstream through a 2-entry skid buffer so that downstream back-pressure never drops data.
- Also keeps a wrapping count of completed output transfers.

Parameters:
CNT_W, 16, width of the completed-transfer counter EXT_CNT

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  synchronous active-high reset
IN_VALID  input  1  upstream presents INSTR/IMM_SEL
IN_READY  output  1  stage can accept; registered
INSTR  input  32  instruction word
IMM_SEL  input  2  immediate format select
FLUSH  input  1  synchronous discard of all buffered entries
OUT_VALID  output  1  EXT holds a valid result
OUT_READY  input  1  downstream accepts EXT
EXT  output  32  extended immediate
EXT_CNT  output  CNT_W  number of completed output transfers, modulo 2^CNT_W

Behaviour:
- Extension is combinational on input and is stored already-extended:
  - IMM_SEL=00: {{16{INSTR[15]}}, INSTR[15:0]} (signed 16)
  - IMM_SEL=01: {16'b0, INSTR[15:0]} (zero 16)
  - IMM_SEL=10: {{11{INSTR[20]}}, INSTR[20:0]} (signed 21, branch/jump offset)
  - IMM_SEL=11: {INSTR[15:0], 16'b0} (upper immediate)
- State:
  - main entry: M_VALID, M_DATA; drives OUT_VALID and EXT.
  - skid entry: S_VALID, S_DATA.
  - IN_READY = ~S_VALID, taken from the register, never combinational from OUT_READY.
- Definitions: accept = IN_VALID & IN_READY; consume = OUT_VALID & OUT_READY.
- Per-cycle update when neither RST nor FLUSH is asserted:
  - M empty, or consume: M loads S if S_VALID, else the accepted data if accept; otherwise M_VALID goes to 0.
  - M full and no consume: M holds; if accept, S loads the accepted data.
  - S drained into M and accept in the same cycle: new data goes into S. No loss and ordering is preserved.
  - S_VALID and M stalled: IN_READY=0, so no accept is possible.
- Latency: accept in cycle N gives OUT_VALID=1 with that data in cycle N+1 when the buffer was empty.
- Throughput is 1 per cycle with OUT_READY held high.
- EXT_CNT increments by 1 on every consume and wraps from 2^CNT_W-1 to 0.
- FLUSH:
  - Next edge: M_VALID=0, S_VALID=0.
  - A same-cycle accept is discarded.
  - A same-cycle consume still counts in EXT_CNT.
  - EXT_CNT is otherwise preserved.
- RST, with priority over FLUSH:
  - OUT_VALID=0, EXT=0, internal S_DATA=0, S_VALID=0, IN_READY=1 from the first cycle after reset, EXT_CNT=0.
  - Reset mid-transfer discards all entries.
- EXT is stable while OUT_VALID=1 and OUT_READY=0.
- IMM_SEL and INSTR are sampled only on accept.

Test Plan:
- Formats: accept INSTR=32'h0000_8001 with IMM_SEL=00/01/11, then INSTR=32'h0010_0000 with IMM_SEL=10, one per cycle with OUT_READY=1 -> EXT=FFFF8001, 00008001, 80010000, FFF00000 on consecutive cycles; EXT_CNT=4.
- Back-pressure: OUT_READY=0, stream 3 words A,B,C -> A in M, B in S, IN_READY=0 after B, C held upstream; raise OUT_READY -> A,B,C emerge in order, one per cycle, none lost.
- Simultaneous drain and accept: M=A, S=B, OUT_READY=1 and IN_VALID=1 with C in the same cycle (IN_READY=0) -> C not taken that cycle; next cycle IN_READY=1, C accepted, order A,B,C.
- Flush: M and S full, FLUSH=1 with IN_VALID=1 -> next cycle OUT_VALID=0, IN_READY=1, flushed data never appears, EXT_CNT unchanged.
- Reset mid-operation: buffer full, EXT_CNT=5, RST=1 for one cycle -> OUT_VALID=0, EXT=0, EXT_CNT=0, IN_READY=1.
- Counter wrap with CNT_W=4: 17 consumes -> EXT_CNT reads 1.
